// File: rtl/bsg_manycore_ret_endpoint_if.sv
// Valid/ready channel carrying one return packet.
// Ports (modports):
//   master : drives v/data, samples ready  (packet producer)
//   slave  : samples v/data, drives ready  (packet consumer)
interface bsg_manycore_ret_endpoint_if #(
    parameter int unsigned width_p = 15
);
    logic               v;
    logic [width_p-1:0] data;
    logic               ready;

    modport master (output v, output data, input ready);
    modport slave  (input v, input data, output ready);
endinterface

// File: rtl/bsg_manycore_ret_endpoint.sv
// Return-network endpoint for a manycore tile.
// Queues return packets for incoming remote stores the local proc has
// consumed, tracks outstanding outgoing remote stores as a credit count, and
// records the status of the most recent return received.
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   req_done_*              local proc finished one incoming store (src x/y, status)
//   req_done_ready_o        return queue not full
//   ret_out (master)        return packets toward the return-router proc port
//   ret_in  (slave)         return packets arriving from the return router (always sunk)
//   out_v_i                 one outgoing remote store handed to the request router
//   out_credits_o           outstanding store count
//   out_credit_avail_o      count below max_out_credits_p
//   all_done_o              no outstanding stores and own queue empty
//   last_status_o           status of the latest received return
//   err_o                   sticky protocol error
module bsg_manycore_ret_endpoint #(
    parameter int unsigned x_cord_width_p    = 5,
    parameter int unsigned y_cord_width_p    = 5,
    parameter int unsigned max_out_credits_p = 16,
    parameter int unsigned ret_fifo_els_p    = 2,
    localparam int unsigned ret_packet_width_lp = 5 + x_cord_width_p + y_cord_width_p,
    localparam int unsigned credit_width_lp     = $clog2(max_out_credits_p + 1)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,

    input  logic                       req_done_v_i,
    input  logic [x_cord_width_p-1:0]  req_src_x_i,
    input  logic [y_cord_width_p-1:0]  req_src_y_i,
    input  logic [4:0]                 req_status_i,
    output logic                       req_done_ready_o,

    bsg_manycore_ret_endpoint_if.master ret_out,
    bsg_manycore_ret_endpoint_if.slave  ret_in,

    input  logic                       out_v_i,
    output logic [credit_width_lp-1:0] out_credits_o,
    output logic                       out_credit_avail_o,
    output logic                       all_done_o,
    output logic [4:0]                 last_status_o,
    output logic                       err_o
);

    localparam int unsigned ptr_width_lp = (ret_fifo_els_p > 1) ? $clog2(ret_fifo_els_p) : 1;
    localparam int unsigned cnt_width_lp = $clog2(ret_fifo_els_p + 1);

    logic [ret_packet_width_lp-1:0] mem [ret_fifo_els_p];
    logic [ptr_width_lp-1:0]        rd_ptr;
    logic [ptr_width_lp-1:0]        wr_ptr;
    logic [cnt_width_lp-1:0]        fifo_cnt;

    logic fifo_full;
    logic fifo_empty;
    logic enq;
    logic deq;

    // Ring-pointer advance; depth need not be a power of two.
    function automatic logic [ptr_width_lp-1:0] next_ptr(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(ret_fifo_els_p - 1)) ? '0 : p + ptr_width_lp'(1);
    endfunction

    // Full is taken from the registered count only, so a dequeue in the same
    // cycle never opens a slot for an enqueue and ready never depends on ret_out.ready.
    assign fifo_full  = (fifo_cnt == cnt_width_lp'(ret_fifo_els_p));
    assign fifo_empty = (fifo_cnt == '0);
    assign enq        = req_done_v_i & ~fifo_full;
    assign deq        = ~fifo_empty & ret_out.ready;

    assign req_done_ready_o = ~fifo_full;
    assign ret_out.v        = ~fifo_empty;
    assign ret_out.data     = mem[rd_ptr];
    assign ret_in.ready     = 1'b1;

    // Queue storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wr_ptr] <= {req_status_i, req_src_y_i, req_src_x_i};
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (enq) wr_ptr <= next_ptr(wr_ptr);
            if (deq) rd_ptr <= next_ptr(rd_ptr);
            case ({enq, deq})
                2'b10:   fifo_cnt <= fifo_cnt + cnt_width_lp'(1);
                2'b01:   fifo_cnt <= fifo_cnt - cnt_width_lp'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Outstanding-store credits, last return status and sticky error.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_credits_o <= '0;
            last_status_o <= '0;
            err_o         <= 1'b0;
        end else begin
            if (ret_in.v) begin
                last_status_o <= ret_in.data[ret_packet_width_lp-1 -: 5];
            end
            if (out_v_i & ~ret_in.v) begin
                if (out_credits_o == credit_width_lp'(max_out_credits_p)) err_o <= 1'b1;
                else out_credits_o <= out_credits_o + credit_width_lp'(1);
            end
            if (ret_in.v & ~out_v_i) begin
                if (out_credits_o == '0) err_o <= 1'b1;
                else out_credits_o <= out_credits_o - credit_width_lp'(1);
            end
            if (req_done_v_i & fifo_full) begin
                err_o <= 1'b1;
            end
        end
    end

    assign out_credit_avail_o = (out_credits_o < credit_width_lp'(max_out_credits_p));
    assign all_done_o         = (out_credits_o == '0) & fifo_empty;

endmodule

// File: tb/tb_bsg_manycore_ret_endpoint.sv
// Directed and randomized checks of bsg_manycore_ret_endpoint against a
// queue/integer reference model.
module tb_bsg_manycore_ret_endpoint;

    localparam int unsigned XW   = 5;
    localparam int unsigned YW   = 5;
    localparam int unsigned MAXC = 16;
    localparam int unsigned ELS  = 2;
    localparam int unsigned PW   = 5 + XW + YW;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_done_v = 1'b0;
    logic [XW-1:0] req_src_x = '0;
    logic [YW-1:0] req_src_y = '0;
    logic [4:0]    req_status = '0;
    logic          req_done_ready;
    logic          out_v = 1'b0;
    logic [CW-1:0] out_credits;
    logic          out_credit_avail;
    logic          all_done;
    logic [4:0]    last_status;
    logic          err;

    always #5 clk = ~clk;

    bsg_manycore_ret_endpoint_if #(.width_p(PW)) ret_out ();
    bsg_manycore_ret_endpoint_if #(.width_p(PW)) ret_in ();

    bsg_manycore_ret_endpoint #(
        .x_cord_width_p    (XW),
        .y_cord_width_p    (YW),
        .max_out_credits_p (MAXC),
        .ret_fifo_els_p    (ELS)
    ) dut (
        .clk_i              (clk),
        .reset_i            (reset),
        .req_done_v_i       (req_done_v),
        .req_src_x_i        (req_src_x),
        .req_src_y_i        (req_src_y),
        .req_status_i       (req_status),
        .req_done_ready_o   (req_done_ready),
        .ret_out            (ret_out),
        .ret_in             (ret_in),
        .out_v_i            (out_v),
        .out_credits_o      (out_credits),
        .out_credit_avail_o (out_credit_avail),
        .all_done_o         (all_done),
        .last_status_o      (last_status),
        .err_o              (err)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [PW-1:0] mq[$];
    int            mcred  = 0;
    bit            merr   = 1'b0;
    logic [4:0]    mstat  = '0;
    bit            mvalid = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_ret_v"}, 32'(ret_out.v), 32'(mq.size() != 0));
        if (mq.size() != 0) check({tag, "_ret_data"}, 32'(ret_out.data), 32'(mq[0]));
        check({tag, "_ready"}, 32'(req_done_ready), 32'(mq.size() < ELS));
        check({tag, "_credits"}, 32'(out_credits), 32'(mcred));
        check({tag, "_avail"}, 32'(out_credit_avail), 32'(mcred < MAXC));
        check({tag, "_all_done"}, 32'(all_done), 32'(mcred == 0 && mq.size() == 0));
        check({tag, "_last_status"}, 32'(last_status), 32'(mstat));
        check({tag, "_err"}, 32'(err), 32'(merr));
        check({tag, "_ret_ready_o"}, 32'(ret_in.ready), 32'd1);
    endtask

    // Drive one cycle of inputs, check outputs against the model, advance model and clock.
    task automatic cycle(input string tag, input bit rst, input bit dv, input int x, input int y,
                         input int st, input bit rr, input bit ov, input bit iv, input int idata);
        bit full;
        reset       = rst;
        req_done_v  = dv;
        req_src_x   = XW'(x);
        req_src_y   = YW'(y);
        req_status  = 5'(st);
        ret_out.ready = rr;
        out_v       = ov;
        ret_in.v    = iv;
        ret_in.data = PW'(idata);
        #1;
        if (mvalid) check_all(tag);
        if (rst) begin
            mq.delete();
            mcred = 0; merr = 1'b0; mstat = '0; mvalid = 1'b1;
        end else begin
            full = (mq.size() >= ELS);
            if (mq.size() != 0 && rr) void'(mq.pop_front());
            if (dv && !full) mq.push_back({5'(st), YW'(y), XW'(x)});
            if (dv && full) merr = 1'b1;
            if (iv) mstat = 5'(idata >> (PW - 5));
            if (ov && !iv) begin
                if (mcred == MAXC) merr = 1'b1; else mcred++;
            end
            if (iv && !ov) begin
                if (mcred == 0) merr = 1'b1; else mcred--;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        ret_out.ready = 1'b0;
        ret_in.v      = 1'b0;
        ret_in.data   = '0;
        @(posedge clk); #1;

        cycle("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset_ret_v", 32'(ret_out.v), 32'd0);
        check("reset_ready", 32'(req_done_ready), 32'd1);
        check("reset_err", 32'(err), 32'd0);

        // Three outgoing stores, then three returns with status 1
        for (int i = 0; i < 3; i++) cycle("c037_out", 0, 0, 0, 0, 0, 1, 1, 0, 0);
        check("c037_credits3", 32'(out_credits), 32'd3);
        check("c037_not_done", 32'(all_done), 32'd0);
        for (int i = 0; i < 3; i++) cycle("c037_ret", 0, 0, 0, 0, 0, 1, 0, 1, 32'h0400 | i);
        check("c037_credits0", 32'(out_credits), 32'd0);
        check("c037_done", 32'(all_done), 32'd1);
        check("c037_status", 32'(last_status), 32'h01);

        // Single return packet, drained next cycle
        cycle("c038_enq", 0, 1, 2, 3, 0, 1, 0, 0, 0);
        check("c038_ret_v", 32'(ret_out.v), 32'd1);
        check("c038_ret_data", 32'(ret_out.data), 32'h0062);
        cycle("c038_deq", 0, 0, 0, 0, 0, 1, 0, 0, 0);
        check("c038_empty", 32'(ret_out.v), 32'd0);

        // Backpressure: two fit, third is dropped and flags an error
        cycle("c039_a", 0, 1, 1, 4, 7, 0, 0, 0, 0);
        cycle("c039_b", 0, 1, 9, 6, 3, 0, 0, 0, 0);
        check("c039_full", 32'(req_done_ready), 32'd0);
        check("c039_head_stable", 32'(ret_out.data), 32'({5'd7, 5'd4, 5'd1}));
        cycle("c039_c", 0, 1, 5, 5, 5, 0, 0, 0, 0);
        check("c039_err", 32'(err), 32'd1);
        cycle("c039_d1", 0, 0, 0, 0, 0, 1, 0, 0, 0);
        check("c039_second", 32'(ret_out.data), 32'({5'd3, 5'd6, 5'd9}));
        cycle("c039_d2", 0, 0, 0, 0, 0, 1, 0, 0, 0);
        check("c039_drained", 32'(ret_out.v), 32'd0);

        // Full queue with simultaneous dequeue: enqueue refused
        cycle("c029_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("c029_a", 0, 1, 1, 1, 1, 0, 0, 0, 0);
        cycle("c029_b", 0, 1, 2, 2, 2, 0, 0, 0, 0);
        cycle("c029_c", 0, 1, 3, 3, 3, 1, 0, 0, 0);
        check("c029_one_left", 32'(ret_out.data), 32'({5'd2, 5'd2, 5'd2}));

        // Credit saturation
        cycle("c040_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < MAXC; i++) cycle("c040_fill", 0, 0, 0, 0, 0, 1, 1, 0, 0);
        check("c040_at_max", 32'(out_credits), 32'(MAXC));
        cycle("c040_both", 0, 0, 0, 0, 0, 1, 1, 1, 32'h7c00);
        check("c040_both_cred", 32'(out_credits), 32'(MAXC));
        check("c040_both_err", 32'(err), 32'd0);
        check("c040_both_status", 32'(last_status), 32'h1f);
        cycle("c040_over", 0, 0, 0, 0, 0, 1, 1, 0, 0);
        check("c040_over_cred", 32'(out_credits), 32'(MAXC));
        check("c040_over_err", 32'(err), 32'd1);
        check("c040_over_avail", 32'(out_credit_avail), 32'd0);

        // Underflow, then reset with returns queued
        cycle("c041_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("c041_under", 0, 0, 0, 0, 0, 1, 0, 1, 32'h0800);
        check("c041_under_cred", 32'(out_credits), 32'd0);
        check("c041_under_err", 32'(err), 32'd1);
        cycle("c041_q1", 0, 1, 4, 4, 4, 0, 0, 0, 0);
        cycle("c041_q2", 0, 1, 6, 6, 6, 0, 1, 0, 0);
        cycle("c041_reset", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("c041_rst_ret_v", 32'(ret_out.v), 32'd0);
        check("c041_rst_err", 32'(err), 32'd0);
        check("c041_rst_cred", 32'(out_credits), 32'd0);

        // Randomized traffic, with occasional mid-run reset
        for (int i = 0; i < 3000; i++) begin
            bit ov, iv;
            ov = ($urandom_range(0, 99) < ((mcred < MAXC - 2) ? 45 : 20));
            iv = ($urandom_range(0, 99) < ((mcred > 2) ? 45 : 15));
            cycle("rand", ($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 99) < 50),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                  ($urandom_range(0, 99) < 60), ov, iv, int'($urandom_range(0, 32767)));
        end
        cycle("final", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
